// File: rtl/stk_client_if.sv
// stk_pkg / stk_client_if: stack opcodes and the request, command and response
// signal bundle between a local user, stk_client and the shared stack.
package stk_pkg;
    typedef enum logic [1:0] {NOP = 2'd0, PUSH = 2'd1, POP = 2'd2} opcode_t;
endpackage

interface stk_client_if;
    import stk_pkg::*;
    logic           i_req_vld;
    opcode_t        i_req_opcode;
    logic [127:0]   i_req_dat;
    logic           o_req_rdy;
    opcode_t        o_cmd_opcode;
    logic [127:0]   o_cmd_dat;
    logic           i_cmd_ack;
    logic           i_rsp_vld;
    logic [127:0]   i_rsp_dat;
    logic           o_rsp_vld;
    logic [127:0]   o_rsp_dat;
    logic           o_rsp_err;
    logic           i_rsp_rdy;
    modport slave (
        input  i_req_vld, i_req_opcode, i_req_dat, i_cmd_ack, i_rsp_vld, i_rsp_dat, i_rsp_rdy,
        output o_req_rdy, o_cmd_opcode, o_cmd_dat, o_rsp_vld, o_rsp_dat, o_rsp_err
    );
    modport master (
        output i_req_vld, i_req_opcode, i_req_dat, i_cmd_ack, i_rsp_vld, i_rsp_dat, i_rsp_rdy,
        input  o_req_rdy, o_cmd_opcode, o_cmd_dat, o_rsp_vld, o_rsp_dat, o_rsp_err
    );
endinterface

// File: rtl/stk_client.sv
// stk_client: one-outstanding PUSH/POP client of a shared stack with response hold.
// Define STK_CLIENT_WATCHDOG_EN to build the POP response watchdog (TMO_CYC cycles).
module stk_client import stk_pkg::*; #(
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 200
) (
    input  logic        clk,
    input  logic        arst,
    stk_client_if.slave bus
);
    if (TMO_CYC < 1 || TMO_CYC > (2 ** TMO_W) - 1) begin : g_bad_tmo
        $error("stk_client: TMO_CYC out of range for TMO_W");
    end

    typedef enum logic [1:0] {IDLE, CMD, WAIT, HOLD} state_t;

    state_t       state_q, state_d;
    opcode_t      op_q, op_d;
    logic [127:0] dat_q, dat_d;
    logic [127:0] rdat_q, rdat_d;
`ifdef STK_CLIENT_WATCHDOG_EN
    logic             err_q, err_d;
    logic [TMO_W-1:0] wd_q, wd_d;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            op_q    <= NOP;
            dat_q   <= '0;
            rdat_q  <= '0;
`ifdef STK_CLIENT_WATCHDOG_EN
            err_q   <= 1'b0;
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
`ifdef STK_CLIENT_WATCHDOG_EN
            err_q   <= err_d;
            wd_q    <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
`ifdef STK_CLIENT_WATCHDOG_EN
        err_d   = err_q;
        wd_d    = wd_q;
`endif
        case (state_q)
            IDLE: if (bus.i_req_vld && bus.i_req_opcode != NOP) begin
                op_d    = bus.i_req_opcode;
                dat_d   = bus.i_req_dat;
                state_d = CMD;
            end
            CMD: if (bus.i_cmd_ack) begin
                state_d = (op_q == POP) ? WAIT : IDLE;
`ifdef STK_CLIENT_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            WAIT: begin
`ifdef STK_CLIENT_WATCHDOG_EN
                wd_d = (&wd_q) ? wd_q : wd_q + 1'b1;
`endif
                // A response arriving on the expiry cycle takes priority over the timeout.
                if (bus.i_rsp_vld) begin
                    rdat_d  = bus.i_rsp_dat;
                    state_d = HOLD;
`ifdef STK_CLIENT_WATCHDOG_EN
                    err_d   = 1'b0;
                end else if (wd_q == TMO_W'(TMO_CYC - 1)) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
`endif
                end
            end
            HOLD: if (bus.i_rsp_rdy) state_d = IDLE;
        endcase
    end

    assign bus.o_req_rdy    = state_q == IDLE;
    assign bus.o_cmd_opcode = (state_q == CMD) ? op_q : NOP;
    assign bus.o_cmd_dat    = (state_q == CMD) ? dat_q : '0;
    assign bus.o_rsp_vld    = state_q == HOLD;
    assign bus.o_rsp_dat    = (state_q == HOLD) ? rdat_q : '0;
`ifdef STK_CLIENT_WATCHDOG_EN
    assign bus.o_rsp_err    = (state_q == HOLD) && err_q;
`else
    assign bus.o_rsp_err    = 1'b0;
`endif
endmodule

// File: tb/tb_stk_client.sv
// tb_stk_client: directed and random stimulus for stk_client, checked against a
// transaction-queue reference model (watchdog cases only with STK_CLIENT_WATCHDOG_EN).
module tb_stk_client;
    import stk_pkg::*;
    localparam int TMO_CYC = 10;
`ifdef STK_CLIENT_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct {opcode_t op; logic [127:0] dat;} cmd_t;
    typedef struct {logic [127:0] dat; logic err;} rsp_t;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    stk_client_if bus();
    stk_client #(.TMO_W(8), .TMO_CYC(TMO_CYC)) dut (.clk(clk), .arst(arst), .bus(bus));

    cmd_t    cq[$];
    rsp_t    rq[$];
    opcode_t acked[$];
    bit      awaiting;
    int      wcnt;
    int      errors = 0;
    int      checks = 0;
    logic [127:0] a5 = {16{8'hA5}};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("req_rdy", bus.o_req_rdy, cq.size() == 0 && !awaiting && rq.size() == 0);
        chk("cmd_op", bus.o_cmd_opcode, cq.size() != 0 ? cq[0].op : NOP);
        chk("cmd_dat", bus.o_cmd_dat, cq.size() != 0 ? cq[0].dat : '0);
        chk("rsp_vld", bus.o_rsp_vld, rq.size() != 0);
        chk("rsp_dat", bus.o_rsp_dat, rq.size() != 0 ? rq[0].dat : '0);
        chk("rsp_err", bus.o_rsp_err, rq.size() != 0 ? rq[0].err : 1'b0);
    endtask

    task automatic model_clear();
        cq.delete();
        rq.delete();
        awaiting = 0;
        wcnt = 0;
    endtask

    // One clock: drive inputs (caller sits at a negedge), advance model at posedge, check at negedge.
    task automatic tick(input logic rv, input opcode_t op, input logic [127:0] d, input logic ack,
                        input logic sv, input logic [127:0] sd, input logic rr);
        rsp_t r;
        bus.i_req_vld = rv; bus.i_req_opcode = op; bus.i_req_dat = d;
        bus.i_cmd_ack = ack; bus.i_rsp_vld = sv; bus.i_rsp_dat = sd; bus.i_rsp_rdy = rr;
        if (ack && bus.o_cmd_opcode != NOP) acked.push_back(bus.o_cmd_opcode);
        @(posedge clk);
        if (cq.size() != 0) begin
            if (ack) begin
                if (cq[0].op == POP) begin awaiting = 1; wcnt = 0; end
                void'(cq.pop_front());
            end
        end else if (awaiting) begin
            wcnt++;
            if (sv) begin
                r.dat = sd; r.err = 1'b0; rq.push_back(r); awaiting = 0;
            end else if (WD && wcnt == TMO_CYC) begin
                r.dat = '0; r.err = 1'b1; rq.push_back(r); awaiting = 0;
            end
        end else if (rq.size() != 0) begin
            if (rr) void'(rq.pop_front());
        end else if (rv && op != NOP) begin
            cq.push_back('{op, d});
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, NOP, '0, 0, 0, '0, 0);
    endtask

    initial begin
        bus.i_req_vld = 0; bus.i_req_opcode = NOP; bus.i_req_dat = '0; bus.i_cmd_ack = 0;
        bus.i_rsp_vld = 0; bus.i_rsp_dat = '0; bus.i_rsp_rdy = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        check_outputs();

        // PUSH held three cycles, acked on the third
        tick(1, PUSH, a5, 0, 0, '0, 0);
        tick(0, NOP, '0, 0, 0, '0, 0);
        tick(0, NOP, '0, 0, 0, '0, 0);
        tick(0, NOP, '0, 1, 0, '0, 0);
        chk("push_done_rdy", bus.o_req_rdy, 1'b1);

        // spurious response while idle
        tick(0, NOP, '0, 0, 1, 128'hFF, 0);
        chk("spurious_vld", bus.o_rsp_vld, 1'b0);

        // POP, response after 5 cycles, consumer stalls 4 cycles
        tick(1, POP, '0, 0, 0, '0, 0);
        tick(0, NOP, '0, 1, 0, '0, 0);
        idle(4);
        tick(0, NOP, '0, 0, 1, 128'h1234, 0);
        chk("pop_rsp_dat", bus.o_rsp_dat, 128'h1234);
        idle(4);
        tick(0, NOP, '0, 0, 0, '0, 1);
        chk("pop_done_rdy", bus.o_req_rdy, 1'b1);

`ifdef STK_CLIENT_WATCHDOG_EN
        begin
            int n = 0;
            tick(1, POP, '0, 0, 0, '0, 0);
            tick(0, NOP, '0, 1, 0, '0, 0);
            while (!bus.o_rsp_vld && n < 3 * TMO_CYC) begin
                tick(0, NOP, '0, 0, 0, '0, 0);
                n++;
            end
            chk("wd_latency", n, TMO_CYC);
            chk("wd_err", bus.o_rsp_err, 1'b1);
            tick(0, NOP, '0, 0, 0, '0, 1);
            tick(1, POP, '0, 0, 0, '0, 0);
            tick(0, NOP, '0, 1, 0, '0, 0);
            idle(TMO_CYC - 1);
            tick(0, NOP, '0, 0, 1, 128'hBEEF, 0);
            chk("wd_race_err", bus.o_rsp_err, 1'b0);
            chk("wd_race_dat", bus.o_rsp_dat, 128'hBEEF);
            tick(0, NOP, '0, 0, 0, '0, 1);
        end
`endif

        // reset pulse while a POP is presented
        tick(1, POP, 128'h77, 0, 0, '0, 0);
        arst = 1'b1;
        #1;
        model_clear();
        check_outputs();
        #1 arst = 1'b0;
        tick(0, NOP, '0, 1, 0, '0, 0);
        tick(0, NOP, '0, 0, 1, 128'h99, 0);
        idle(2);
        chk("rst_no_rsp", bus.o_rsp_vld, 1'b0);

        // back-to-back PUSH, POP, NOP, PUSH with immediate acks
        acked.delete();
        tick(1, PUSH, 128'h1, 0, 0, '0, 0);
        tick(0, NOP, '0, 1, 0, '0, 0);
        tick(1, POP, '0, 0, 0, '0, 0);
        tick(0, NOP, '0, 1, 0, '0, 0);
        tick(0, NOP, '0, 0, 1, 128'h2, 1);
        tick(0, NOP, '0, 0, 0, '0, 1);
        tick(1, NOP, 128'h3, 1, 0, '0, 0);
        tick(1, PUSH, 128'h4, 0, 0, '0, 0);
        tick(0, NOP, '0, 1, 0, '0, 0);
        chk("order_len", acked.size(), 3);
        if (acked.size() == 3) begin
            chk("order_0", acked[0], PUSH);
            chk("order_1", acked[1], POP);
            chk("order_2", acked[2], PUSH);
        end

        // random traffic
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 1), opcode_t'($urandom_range(0, 2)),
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1),
                 $urandom_range(0, 9) < 2, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
